// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory with byte lanes, fixed access latency and a stall handshake
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadDataM,
    output logic        stall,
    output logic        mem_err
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   addr_q, rd_q, lane_mask, rd_word;
    logic [3:0]    cnt, cnt_nxt;
    logic [AW-1:0] idx;
    logic          req, oor, both, pure_rd, mismatch, arrive, commit, err_evt;

    assign req       = MemReadM | MemWriteM;
    assign both      = MemReadM & MemWriteM;
    assign pure_rd   = MemReadM & ~MemWriteM;
    assign idx       = ALUResultM[AW+1:2];
    assign oor       = (ALUResultM >> (AW + 2)) != 32'd0;
    assign lane_mask = {{8{byteEnable[3]}}, {8{byteEnable[2]}}, {8{byteEnable[1]}}, {8{byteEnable[0]}}};
    assign rd_word   = oor ? 32'd0 : mem[idx] & lane_mask;

    // An address change mid-access restarts the access from the first counted cycle.
    assign mismatch  = req && cnt != 4'd0 && ALUResultM != addr_q;
    assign stall     = reset && req && LAT != 4'd0 && (cnt < LAT || mismatch);
    assign cnt_nxt   = mismatch ? 4'd1 : cnt + 4'd1;
    // Edge that leads into the completion cycle; read data and completion errors are registered here.
    assign arrive    = stall && cnt_nxt == LAT;
    assign commit    = reset && req && MemWriteM && !oor && cnt == LAT && !mismatch;
    assign err_evt   = mismatch || ((LAT == 4'd0 ? req : arrive) && (oor || both));
    assign ReadDataM = LAT == 4'd0 ? (reset ? rd_word : 32'd0) : rd_q;

    // Access sequencing: stall counter, captured address, registered read data and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            rd_q    <= '0;
            mem_err <= 1'b0;
        end else begin
            mem_err <= err_evt;
            if (!req) begin
                cnt <= '0;
            end else if (mismatch) begin
                cnt    <= 4'd1;
                addr_q <= ALUResultM;
            end else if (cnt < LAT) begin
                cnt <= cnt_nxt;
                if (cnt == 4'd0) addr_q <= ALUResultM;
            end else begin
                cnt <= '0;
            end
            if (arrive && pure_rd) rd_q <= rd_word;
        end
    end

    // Byte-lane write, committed only on the completion edge of an in-range write
    always_ff @(posedge clk) begin
        if (commit)
            for (int i = 0; i < 4; i++)
                if (byteEnable[i]) mem[idx][8*i +: 8] <= WriteDataM[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for the latency-2 and latency-0 memory responders
module tb_data_mem_responder;
    logic        clk = 1'b0, reset = 1'b0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0, WriteDataM = '0;
    logic [3:0]  byteEnable = '0;
    logic [31:0] ReadDataM;
    logic        stall, mem_err;
    logic        z_rd = 1'b0, z_wr = 1'b0;
    logic [31:0] z_addr = 32'hC, z_wdata = '0;
    logic [3:0]  z_be = 4'hF;
    logic [31:0] z_rdata;
    logic        z_stall, z_err;

    int          errors = 0, checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [256];
    logic [31:0] last_rd = '0;
    logic [31:0] v;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .byteEnable(byteEnable),
        .ReadDataM(ReadDataM), .stall(stall), .mem_err(mem_err)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .MemReadM(z_rd), .MemWriteM(z_wr),
        .ALUResultM(z_addr), .WriteDataM(z_wdata), .byteEnable(z_be),
        .ReadDataM(z_rdata), .stall(z_stall), .mem_err(z_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int          n;
        logic        o, e;
        logic [31:0] x;
        o = (a >> 10) != 32'd0;
        e = o || (rd && wr);
        if (rd && !wr) exp_q.push_back(o ? 32'h0 : model[a[9:2]] & lanes(be));
        if (wr && !o)
            for (int i = 0; i < 4; i++)
                if (be[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = d; byteEnable = be;
        n = 0;
        @(negedge clk);
        while (stall && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(n), 32'd2);
        if (rd && !wr) begin
            x = exp_q.pop_front();
            chk("rdata", ReadDataM, x);
            last_rd = x;
        end else if (rd) begin
            chk("rdata_hold", ReadDataM, last_rd);
        end
        chk("mem_err", {31'd0, mem_err}, {31'd0, e});
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = '0;
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        access(1'b0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010);
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'b1100);
        access(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000);
        access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        access(1'b1, 1'b1, 32'h30, 32'h77778888, 4'hF);
        access(1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h40, 32'h40404040, 4'hF);
        access(1'b0, 1'b1, 32'h44, 32'h44445555, 4'hF);
        exp_q.push_back(model[8'h11]);
        MemReadM = 1'b1; ALUResultM = 32'h40; byteEnable = 4'hF;
        @(negedge clk); chk("mm_stall0", {31'd0, stall}, 32'd1);
        @(posedge clk); #1; ALUResultM = 32'h44;
        @(negedge clk); chk("mm_stall1", {31'd0, stall}, 32'd1); chk("mm_err0", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("mm_stall2", {31'd0, stall}, 32'd1); chk("mm_err1", {31'd0, mem_err}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("mm_stall3", {31'd0, stall}, 32'd0); chk("mm_err2", {31'd0, mem_err}, 32'd0);
        chk("mm_rdata", ReadDataM, exp_q.pop_front());
        @(posedge clk); #1; MemReadM = 1'b0;
        access(1'b0, 1'b1, 32'h0, 32'h0BADCAFE, 4'hF);
        access(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF);
        @(negedge clk); chk("oor_err_once", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        access(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        access(1'b0, 1'b1, 32'h8, 32'h0BADF00D, 4'hF);
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        MemWriteM = 1'b1; ALUResultM = 32'h8; WriteDataM = 32'hCAFEF00D; byteEnable = 4'hF;
        @(posedge clk); #1; reset = 1'b0; #1;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_rdata", ReadDataM, 32'd0);
        @(negedge clk); MemWriteM = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            v = k[0] ? 32'h5A5A5A5A : 32'hA5A5A5A5;
            @(posedge clk); #1; z_wr = 1'b1; z_rd = 1'b0; z_wdata = v;
            @(negedge clk); chk("z_stall_wr", {31'd0, z_stall}, 32'd0);
            exp_q.push_back(v);
            @(posedge clk); #1; z_wr = 1'b0; z_rd = 1'b1;
            @(negedge clk); chk("z_stall_rd", {31'd0, z_stall}, 32'd0);
            chk("z_rdata", z_rdata, exp_q.pop_front());
            chk("z_err", {31'd0, z_err}, 32'd0);
        end
        @(posedge clk); #1; z_rd = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder: the memory-stage counterpart of the pipelined datapath, which acts as the initiator.
- Accepts the datapath's memory-stage request: address, write data, byte enables, and read/write strobes.
- Performs a byte-lane-masked write, or returns read data, after a fixed, parameterised wait.
- Drives `stall` so the datapath freezes its memory and write-back registers while an access is in flight.

Parameters:
- DEPTH, 256: number of 32-bit words in the array; must be a power of two.
- LATENCY, 2: stall cycles per access, 0..15; 0 means single-cycle access.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- MemReadM  input  1  read request
- MemWriteM  input  1  write request
- ALUResultM  input  32  byte address; word index = ALUResultM[log2(DEPTH)+1:2]; bits [1:0] ignored
- WriteDataM  input  32  write data, lane-aligned
- byteEnable  input  4  lane enables; bit i covers bits [8i+7:8i]
- ReadDataM  output  32  read data; disabled lanes read 0
- stall  output  1  high while the current request is not yet complete
- mem_err  output  1  one-cycle error pulse

Behaviour:
- req = MemReadM | MemWriteM.
- Counter cnt, 4 bits, reset 0; registered address addr_q, reset 0.
- Reset (reset=0, asynchronous) clears cnt, addr_q, ReadDataM and mem_err; stall=0 while in reset.
- Array contents are not reset. Reset asserted mid-access abandons that access: no write is committed.
- LATENCY=0:
  - stall is constantly 0.
  - A write commits the enabled lanes at the clock edge of the request cycle.
  - ReadDataM is combinational from the array, masked by byteEnable.
- LATENCY>0, per cycle with req=1:
  - cnt<LATENCY: stall=1 (combinational, same cycle). cnt increments at the edge. addr_q captures ALUResultM when cnt=0.
  - cnt=LATENCY-1: the read word is additionally registered into ReadDataM (masked) at that edge.
  - cnt=LATENCY: completion cycle. stall=0, ReadDataM is valid. A write commits at the edge, then cnt is cleared to 0.
  - Net latency: a request stalls exactly LATENCY cycles and completes in cycle LATENCY+1.
  - Back-to-back requests each pay the full LATENCY.
- req=0: stall=0, cnt cleared to 0, ReadDataM holds its last value.
- Protocol rule: the initiator holds every request input stable while stall=1.
  - If ALUResultM differs from addr_q while 0<cnt<=LATENCY: pulse mem_err, reload cnt to 1, reload addr_q with the new address. The access restarts and no write is committed.
- Out of range (ALUResultM[31:log2(DEPTH)+2] nonzero):
  - The access still takes the full stall sequence.
  - The write is suppressed and the read returns 0.
  - mem_err pulses in the completion cycle.
- MemReadM=1 and MemWriteM=1 together: treated as a write, mem_err pulses in the completion cycle, ReadDataM is not updated.
- byteEnable=0 with req=1: legal no-op. The full stall is taken, nothing is written, and reads return 0.
- mem_err is registered and high for exactly one cycle per event.
- Reads and writes to the same word in consecutive requests: the read observes the earlier write, because that write committed at its completion edge.

Test Plan:
- LATENCY=2. Write 0xDEADBEEF to 0x10 with byteEnable=1111, then read 0x10 with byteEnable=1111 -> stall high for exactly 2 cycles per request; ReadDataM=0xDEADBEEF in the read's completion cycle; mem_err never set.
- Preload 0x11223344 at 0x20. Write 0x0000AA00 with byteEnable=0010, then read with 1111 -> word reads 0x1122AA44. A read with byteEnable=1100 returns 0x11220000.
- Read request at 0x40 (stall high, cnt=1); change ALUResultM to 0x44 -> mem_err pulses one cycle; stall persists for 2 more cycles; completion returns the contents of 0x44.
- DEPTH=256, write 0x12345678 to 0x400 -> full 2-cycle stall; mem_err pulse in the completion cycle; word 0 is unchanged; a read of 0x400 returns 0.
- Assert reset low during the second stall cycle of a write of 0xCAFEF00D to 0x8 -> stall drops immediately, ReadDataM=0, and a later read of 0x8 returns the prior contents.
- LATENCY=0: alternate write 0xA5A5A5A5 to 0xC and read 0xC every cycle -> stall never asserts; the read in the cycle after the write returns 0xA5A5A5A5.
